// File: rtl/usb_fs_nb_out_pe.sv
// Non-buffered USB full-speed OUT/SETUP protocol engine: token decode, payload streaming
// into the OUT endpoint buffer, handshake selection and per-endpoint OUT data toggles.
module usb_fs_nb_out_pe #(
    parameter int unsigned NumOutEps         = 12,
    parameter int unsigned MaxOutPktSizeByte = 64,
    parameter int unsigned AckTimeoutCnt     = 73,
    localparam int unsigned PktW             = $clog2(MaxOutPktSizeByte)
) (
    input  logic                 clk_48mhz_i,
    input  logic                 rst_ni,
    input  logic                 link_reset_i,
    input  logic                 link_active_i,
    input  logic [6:0]           dev_addr_i,
    input  logic                 rx_pkt_start_i,
    input  logic                 rx_pkt_end_i,
    input  logic                 rx_pkt_valid_i,
    input  logic [3:0]           rx_pid_i,
    input  logic [6:0]           rx_addr_i,
    input  logic [3:0]           rx_endp_i,
    input  logic                 rx_data_put_i,
    input  logic [7:0]           rx_data_i,
    output logic                 tx_pkt_start_o,
    output logic [3:0]           tx_pid_o,
    input  logic                 tx_pkt_end_i,
    input  logic [NumOutEps-1:0] out_ep_enabled_i,
    input  logic [NumOutEps-1:0] out_ep_iso_i,
    input  logic [NumOutEps-1:0] out_ep_stall_i,
    input  logic [NumOutEps-1:0] out_ep_full_i,
    output logic [3:0]           out_ep_current_o,
    output logic                 out_ep_newpkt_o,
    output logic                 out_ep_setup_o,
    output logic                 out_ep_data_put_o,
    output logic [PktW-1:0]      out_ep_put_addr_o,
    output logic [7:0]           out_ep_data_o,
    output logic                 out_ep_acked_o,
    output logic                 out_ep_rollback_o,
    output logic [NumOutEps-1:0] out_data_toggle_o
);

    localparam int unsigned CntW = $clog2(AckTimeoutCnt + 1);

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRcvdOut  = 2'd1,
        StRcvdData = 2'd2,
        StDecide   = 2'd3
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [PktW:0]     put_cnt_q;
    logic              overflow_q;
    logic              data_tog_q;
    logic [15:0]       tog_q;
    logic [3:0]        ep_q;
    logic              setup_q;
    logic              newpkt_q;
    logic              data_put_q;
    logic [PktW-1:0]   put_addr_q;
    logic [7:0]        data_q;
    logic              acked_q;
    logic              rollback_q;

    // Per-endpoint vectors widened to 16 so any 4-bit endpoint index stays in range.
    logic [15:0] en_pad_s, iso_pad_s, stall_pad_s, full_pad_s;
    logic        link_ok_s, tok_accept_s, data_pid_ok_s;
    logic        hs_send_s, dec_ack_s, dec_rb_s, dec_flip_s, dec_set_s;
    logic [3:0]  hs_pid_s;
    logic        unused_tx_end_s;

    assign en_pad_s    = 16'(out_ep_enabled_i);
    assign iso_pad_s   = 16'(out_ep_iso_i);
    assign stall_pad_s = 16'(out_ep_stall_i);
    assign full_pad_s  = 16'(out_ep_full_i);
    assign unused_tx_end_s = tx_pkt_end_i;

    assign link_ok_s     = !link_reset_i && link_active_i;
    assign data_pid_ok_s = (rx_pid_i == PidData0) || (rx_pid_i == PidData1);
    assign tok_accept_s  = rx_pkt_end_i && rx_pkt_valid_i
                         && ((rx_pid_i == PidOut) || (rx_pid_i == PidSetup))
                         && (rx_addr_i == dev_addr_i)
                         && (32'(rx_endp_i) < NumOutEps)
                         && en_pad_s[rx_endp_i];

    // Handshake selection for the deciding cycle, highest priority first.
    always_comb begin
        hs_send_s  = 1'b0;
        hs_pid_s   = 4'b0000;
        dec_ack_s  = 1'b0;
        dec_rb_s   = 1'b0;
        dec_flip_s = 1'b0;
        dec_set_s  = 1'b0;
        if (iso_pad_s[ep_q]) begin
            dec_ack_s = !overflow_q;
            dec_rb_s  = overflow_q;
        end else if (!setup_q && stall_pad_s[ep_q]) begin
            hs_send_s = 1'b1;
            hs_pid_s  = PidStall;
            dec_rb_s  = 1'b1;
        end else if (full_pad_s[ep_q] || overflow_q) begin
            hs_send_s = 1'b1;
            hs_pid_s  = PidNak;
            dec_rb_s  = 1'b1;
        end else if (setup_q) begin
            hs_send_s = 1'b1;
            hs_pid_s  = PidAck;
            dec_ack_s = 1'b1;
            dec_set_s = 1'b1;
        end else if (data_tog_q != tog_q[ep_q]) begin
            hs_send_s = 1'b1;
            hs_pid_s  = PidAck;
            dec_rb_s  = 1'b1;
        end else begin
            hs_send_s  = 1'b1;
            hs_pid_s   = PidAck;
            dec_ack_s  = 1'b1;
            dec_flip_s = 1'b1;
        end
    end

    assign tx_pkt_start_o = (state_q == StDecide) && link_ok_s && hs_send_s;
    assign tx_pid_o       = tx_pkt_start_o ? hs_pid_s : 4'b0000;

    // Transaction state machine with its registered buffer-side outputs and toggles.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= CntW'(AckTimeoutCnt);
            put_cnt_q  <= '0;
            overflow_q <= 1'b0;
            data_tog_q <= 1'b0;
            tog_q      <= 16'h0000;
            ep_q       <= 4'h0;
            setup_q    <= 1'b0;
            newpkt_q   <= 1'b0;
            data_put_q <= 1'b0;
            put_addr_q <= '0;
            data_q     <= 8'h00;
            acked_q    <= 1'b0;
            rollback_q <= 1'b0;
        end else begin
            newpkt_q   <= 1'b0;
            data_put_q <= 1'b0;
            acked_q    <= 1'b0;
            rollback_q <= 1'b0;
            if (!link_ok_s) begin
                // Aborted transactions leave the partial packet for the buffer logic.
                state_q   <= StIdle;
                put_cnt_q <= '0;
                if (link_reset_i) begin
                    tog_q <= 16'h0000;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        put_cnt_q <= '0;
                        if (tok_accept_s) begin
                            state_q    <= StRcvdOut;
                            ep_q       <= rx_endp_i;
                            setup_q    <= (rx_pid_i == PidSetup);
                            newpkt_q   <= 1'b1;
                            cnt_q      <= CntW'(AckTimeoutCnt);
                            overflow_q <= 1'b0;
                        end
                    end
                    StRcvdOut: begin
                        if (rx_pkt_start_i) begin
                            state_q <= StRcvdData;
                        end else if (cnt_q == '0) begin
                            state_q    <= StIdle;
                            rollback_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                    StRcvdData: begin
                        if (rx_data_put_i) begin
                            if (!put_cnt_q[PktW]) begin
                                data_put_q <= 1'b1;
                                put_addr_q <= put_cnt_q[PktW-1:0];
                                data_q     <= rx_data_i;
                                put_cnt_q  <= put_cnt_q + (PktW+1)'(1);
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end
                        if (rx_pkt_end_i) begin
                            data_tog_q <= rx_pid_i[3];
                            // SETUP payloads must be DATA0; anything else is a bad PID.
                            if (!rx_pkt_valid_i || !data_pid_ok_s
                                || (setup_q && (rx_pid_i == PidData1))) begin
                                state_q    <= StIdle;
                                rollback_q <= 1'b1;
                            end else begin
                                state_q <= StDecide;
                            end
                        end
                    end
                    StDecide: begin
                        state_q    <= StIdle;
                        acked_q    <= dec_ack_s;
                        rollback_q <= dec_rb_s;
                        if (dec_set_s) begin
                            tog_q[ep_q] <= 1'b1;
                        end else if (dec_flip_s) begin
                            tog_q[ep_q] <= ~tog_q[ep_q];
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign out_ep_current_o  = ep_q;
    assign out_ep_newpkt_o   = newpkt_q;
    assign out_ep_setup_o    = setup_q;
    assign out_ep_data_put_o = data_put_q;
    assign out_ep_put_addr_o = put_addr_q;
    assign out_ep_data_o     = data_q;
    assign out_ep_acked_o    = acked_q;
    assign out_ep_rollback_o = rollback_q;
    assign out_data_toggle_o = tog_q[NumOutEps-1:0];

endmodule

// File: tb/tb_usb_fs_nb_out_pe.sv
// Scoreboard bench for usb_fs_nb_out_pe: expected writes, handshakes and commit/discard
// events are queued as stimulus is driven and checked when the DUT produces them.
module tb_usb_fs_nb_out_pe;

    localparam int NEps = 12;
    localparam logic [3:0] P_OUT = 4'b0001, P_SETUP = 4'b1101;
    localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011;
    localparam logic [3:0] H_ACK = 4'b0010, H_NAK = 4'b1010, H_STALL = 4'b1110;
    localparam logic [6:0] DEV = 7'h2A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic link_reset = 1'b0, link_active = 1'b1;
    logic rx_start = 1'b0, rx_end = 1'b0, rx_valid = 1'b0, rx_put = 1'b0;
    logic [3:0] rx_pid = 4'h0, rx_endp = 4'h0;
    logic [6:0] rx_addr = 7'h00;
    logic [7:0] rx_data = 8'h00;
    logic tx_start, tx_end = 1'b0;
    logic [3:0] tx_pid;
    logic [NEps-1:0] ep_en = 12'hFFF, ep_iso = 12'h008, ep_stall = 12'h000, ep_full = 12'h000;
    logic [3:0] cur;
    logic newpkt, setup, dput, acked, rollback;
    logic [5:0] paddr;
    logic [7:0] pdata;
    logic [NEps-1:0] tog;

    usb_fs_nb_out_pe dut (
        .clk_48mhz_i(clk), .rst_ni(rst_n), .link_reset_i(link_reset), .link_active_i(link_active),
        .dev_addr_i(DEV), .rx_pkt_start_i(rx_start), .rx_pkt_end_i(rx_end),
        .rx_pkt_valid_i(rx_valid), .rx_pid_i(rx_pid), .rx_addr_i(rx_addr), .rx_endp_i(rx_endp),
        .rx_data_put_i(rx_put), .rx_data_i(rx_data), .tx_pkt_start_o(tx_start),
        .tx_pid_o(tx_pid), .tx_pkt_end_i(tx_end), .out_ep_enabled_i(ep_en),
        .out_ep_iso_i(ep_iso), .out_ep_stall_i(ep_stall), .out_ep_full_i(ep_full),
        .out_ep_current_o(cur), .out_ep_newpkt_o(newpkt), .out_ep_setup_o(setup),
        .out_ep_data_put_o(dput), .out_ep_put_addr_o(paddr), .out_ep_data_o(pdata),
        .out_ep_acked_o(acked), .out_ep_rollback_o(rollback), .out_data_toggle_o(tog)
    );

    typedef struct packed { logic [5:0] addr; logic [7:0] data; } wr_t;
    wr_t        wr_q[$];
    logic [3:0] tx_q[$];
    logic       ev_q[$];   // 1 = acked, 0 = rollback
    int checks = 0, errors = 0;
    logic mon_en = 1'b0;
    wr_t m_wr;
    logic [3:0] m_tx;
    logic m_ev;

    // Output monitor: pops the scoreboard whenever the DUT produces something.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dput) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h, required none", paddr, pdata);
                end else begin
                    m_wr = wr_q.pop_front();
                    if ({paddr, pdata} !== {m_wr.addr, m_wr.data}) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 paddr, pdata, m_wr.addr, m_wr.data);
                    end
                end
            end
            if (tx_start) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL handshake_unexpected: got pid=%h, required none", tx_pid);
                end else begin
                    m_tx = tx_q.pop_front();
                    if (tx_pid !== m_tx) begin
                        errors++;
                        $display("FAIL handshake: got pid=%h, required %h", tx_pid, m_tx);
                    end
                end
            end
            if (acked || rollback) begin
                checks++;
                if (ev_q.size() == 0 || (acked && rollback)) begin
                    errors++;
                    $display("FAIL event_unexpected: got acked=%b rollback=%b, required none", acked, rollback);
                end else begin
                    m_ev = ev_q.pop_front();
                    if (acked !== m_ev) begin
                        errors++;
                        $display("FAIL event: got acked=%b rollback=%b, required acked=%b", acked, rollback, m_ev);
                    end
                end
            end
        end
    end

    function automatic int pending();
        return wr_q.size() + tx_q.size() + ev_q.size();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
        rx_pid = pid; rx_addr = addr; rx_endp = ep; rx_end = 1'b1; rx_valid = 1'b1;
        tick();
        rx_end = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] pid, input int n, input logic [7:0] base,
                             input logic expect_wr);
        wr_t w;
        rx_pid = pid; rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_put = 1'b1; rx_data = 8'(base + 8'(i));
            if (expect_wr && i < 64) begin
                w.addr = 6'(i); w.data = rx_data; wr_q.push_back(w);
            end
            tick();
        end
        rx_put = 1'b0;
        rx_end = 1'b1; rx_valid = 1'b1;
        tick();
        rx_end = 1'b0; rx_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        checks++;
        if ({tx_start, tx_pid, cur, newpkt, setup, dput, paddr, pdata, acked, rollback, tog} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got tx=%b pid=%h cur=%h tog=%h, required all zero", tx_start, tx_pid, cur, tog);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        checks++;
        if ({newpkt, acked, rollback, dput, tog} !== 16'd0) begin
            errors++;
            $display("FAIL post_reset: got newpkt=%b acked=%b rb=%b tog=%h, required 0", newpkt, acked, rollback, tog);
        end
    endtask

    task automatic test_out_ack();
        tx_q.push_back(H_ACK); ev_q.push_back(1'b1);
        send_token(P_OUT, DEV, 4'd2);
        checks++;
        if ({newpkt, cur, setup} !== {1'b1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL token_capture: got newpkt=%b cur=%0d setup=%b, required 1 2 0", newpkt, cur, setup);
        end
        send_data(P_D0, 8, 8'h00, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h004) begin
            errors++;
            $display("FAIL out_ack: got pending=%0d tog=%h, required 0 004", pending(), tog);
        end
    endtask

    task automatic test_duplicate();
        tx_q.push_back(H_ACK); ev_q.push_back(1'b0);
        send_token(P_OUT, DEV, 4'd2);
        send_data(P_D0, 8, 8'h00, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h004) begin
            errors++;
            $display("FAIL duplicate: got pending=%0d tog=%h, required 0 004", pending(), tog);
        end
    endtask

    task automatic test_setup_stall();
        ep_stall = 12'h001;
        tx_q.push_back(H_ACK); ev_q.push_back(1'b1);
        send_token(P_SETUP, DEV, 4'd0);
        checks++;
        if ({cur, setup} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL setup_flag: got cur=%0d setup=%b, required 0 1", cur, setup);
        end
        send_data(P_D0, 8, 8'h10, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h005) begin
            errors++;
            $display("FAIL setup_ack: got pending=%0d tog=%h, required 0 005", pending(), tog);
        end
        tx_q.push_back(H_STALL); ev_q.push_back(1'b0);
        send_token(P_OUT, DEV, 4'd0);
        send_data(P_D1, 4, 8'h20, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h005 || setup !== 1'b0) begin
            errors++;
            $display("FAIL stall: got pending=%0d tog=%h setup=%b, required 0 005 0", pending(), tog, setup);
        end
        ev_q.push_back(1'b0);
        send_token(P_SETUP, DEV, 4'd0);
        send_data(P_D1, 2, 8'h30, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h005) begin
            errors++;
            $display("FAIL setup_data1: got pending=%0d tog=%h, required 0 005", pending(), tog);
        end
        ep_stall = 12'h000;
    endtask

    task automatic test_nak();
        ep_full = 12'h002;
        tx_q.push_back(H_NAK); ev_q.push_back(1'b0);
        send_token(P_OUT, DEV, 4'd1);
        send_data(P_D0, 3, 8'h40, 1'b1);
        ep_full = 12'h000;
        checks++;
        if (pending() !== 0 || tog !== 12'h005) begin
            errors++;
            $display("FAIL nak_full: got pending=%0d tog=%h, required 0 005", pending(), tog);
        end
        tx_q.push_back(H_NAK); ev_q.push_back(1'b0);
        send_token(P_OUT, DEV, 4'd4);
        send_data(P_D0, 65, 8'h80, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h005) begin
            errors++;
            $display("FAIL nak_overflow: got pending=%0d tog=%h, required 0 005", pending(), tog);
        end
    endtask

    task automatic test_timeout_iso();
        int seen;
        seen = 0;
        ev_q.push_back(1'b0);
        send_token(P_OUT, DEV, 4'd5);
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (rollback) begin
                seen = k;
                break;
            end
        end
        repeat (3) tick();
        checks++;
        if (seen !== 74 || pending() !== 0) begin
            errors++;
            $display("FAIL timeout: got rollback after %0d cycles pending=%0d, required 74 0", seen, pending());
        end
        ev_q.push_back(1'b1);
        send_token(P_OUT, DEV, 4'd3);
        send_data(P_D0, 5, 8'h50, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h005) begin
            errors++;
            $display("FAIL iso: got pending=%0d tog=%h, required 0 005", pending(), tog);
        end
    endtask

    task automatic test_link_reset();
        wr_t w;
        send_token(P_OUT, DEV, 4'd2);
        rx_pid = P_D1; rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_put = 1'b1; rx_data = 8'(8'h60 + 8'(i));
            w.addr = 6'(i); w.data = rx_data; wr_q.push_back(w);
            tick();
        end
        rx_put = 1'b0;
        link_reset = 1'b1;
        tick();
        link_reset = 1'b0;
        checks++;
        if (tog !== 12'h000) begin
            errors++;
            $display("FAIL link_reset_toggle: got %h, required 000", tog);
        end
        rx_end = 1'b1; rx_valid = 1'b1;
        tick();
        rx_end = 1'b0; rx_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (pending() !== 0) begin
            errors++;
            $display("FAIL link_reset_quiet: got pending=%0d, required 0", pending());
        end
        tx_q.push_back(H_ACK); ev_q.push_back(1'b1);
        send_token(P_OUT, DEV, 4'd2);
        send_data(P_D0, 2, 8'h70, 1'b1);
        checks++;
        if (pending() !== 0 || tog !== 12'h004) begin
            errors++;
            $display("FAIL after_link_reset: got pending=%0d tog=%h, required 0 004", pending(), tog);
        end
    endtask

    task automatic test_bad_token();
        send_token(P_OUT, DEV, 4'd13);
        checks++;
        if ({newpkt, cur} !== {1'b0, 4'd2}) begin
            errors++;
            $display("FAIL bad_endp: got newpkt=%b cur=%0d, required 0 2", newpkt, cur);
        end
        send_data(P_D0, 2, 8'h90, 1'b0);
        send_token(P_OUT, 7'h2B, 4'd1);
        checks++;
        if ({newpkt, cur} !== {1'b0, 4'd2}) begin
            errors++;
            $display("FAIL bad_addr: got newpkt=%b cur=%0d, required 0 2", newpkt, cur);
        end
        send_data(P_D0, 2, 8'hA0, 1'b0);
        checks++;
        if (pending() !== 0 || tog !== 12'h004) begin
            errors++;
            $display("FAIL bad_token_quiet: got pending=%0d tog=%h, required 0 004", pending(), tog);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_out_ack();
        test_duplicate();
        test_setup_stall();
        test_nak();
        test_timeout_iso();
        test_link_reset();
        test_bad_token();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_fs_nb_out_pe.md
# usb_fs_nb_out_pe

Non-buffered USB full-speed protocol engine for OUT and SETUP transactions, sitting between the USB link receive/transmit paths and the OUT endpoint packet buffers. It decodes OUT/SETUP tokens addressed to the device and streams the following DATA0/DATA1 payload bytes to the selected endpoint. It then issues the ACK/NAK/STALL handshake and maintains the per-endpoint OUT data toggles. It is the OUT-direction counterpart of the IN protocol engine.

## Interface
- NumOutEps, 12: number of implemented OUT endpoints (1..16); EpW = $clog2(NumOutEps).
- MaxOutPktSizeByte, 64: maximum payload bytes per packet; PktW = $clog2(MaxOutPktSizeByte).
- AckTimeoutCnt, 73: clock cycles allowed between token end and data packet start, minus one.

Ports:
- clk_48mhz_i  in  1  48 MHz clock; the only clock.
- rst_ni  in  1  asynchronous active-low reset.
- link_reset_i  in  1  bus reset: forces StIdle and clears all toggles.
- link_active_i  in  1  low forces StIdle; toggles are kept.
- dev_addr_i  in  7  device address.
- rx_pkt_start_i / rx_pkt_end_i / rx_pkt_valid_i  in  1 each  receive strobes; valid qualifies end.
- rx_pid_i  in  4  PID of the current packet.
- rx_addr_i  in  7  token address.
- rx_endp_i  in  4  token endpoint.
- rx_data_put_i  in  1  payload byte strobe.
- rx_data_i  in  8  payload byte.
- tx_pkt_start_o  out  1  handshake send strobe.
- tx_pid_o  out  4  handshake PID.
- tx_pkt_end_i  in  1  transmit complete (informational only).
- out_ep_enabled_i / out_ep_iso_i / out_ep_stall_i / out_ep_full_i  in  NumOutEps each  per-endpoint configuration and status.
- out_ep_current_o  out  4  endpoint of the current transaction.
- out_ep_newpkt_o  out  1  transaction start pulse.
- out_ep_setup_o  out  1  current transaction is SETUP.
- out_ep_data_put_o  out  1  write strobe.
- out_ep_put_addr_o  out  PktW  write offset.
- out_ep_data_o  out  8  write data.
- out_ep_acked_o  out  1  pulse: packet committed.
- out_ep_rollback_o  out  1  pulse: packet discarded.
- out_data_toggle_o  out  NumOutEps  current OUT toggles.

## Operation
- Token accepted when all of the following hold:
  - rx_pkt_end_i & rx_pkt_valid_i;
  - PID is OUT or SETUP;
  - rx_addr_i == dev_addr_i;
  - rx_endp_i < NumOutEps;
  - out_ep_enabled_i[ep] is set.
- Tokens failing any condition are ignored with no response.
- States:
  - StIdle: on an accepted token:
    - go to StRcvdOut;
    - capture the endpoint into out_ep_current_o and the setup flag;
    - pulse out_ep_newpkt_o;
    - load the timeout counter to AckTimeoutCnt.
  - StRcvdOut: the counter decrements each cycle.
    - rx_pkt_start_i: go to StRcvdData.
    - Counter == 0 without a start: go to StIdle and pulse out_ep_rollback_o.
  - StRcvdData: each rx_data_put_i with put_addr ≤ MaxOutPktSizeByte-1 writes one byte; put_addr increments.
    - A byte arriving after the buffer is full is not written and sets an overflow flag.
    - On rx_pkt_end_i: if the packet is invalid or its PID is not DATA0/DATA1, go to StIdle and pulse rollback with no handshake.
    - Otherwise go to StDecide.
  - StDecide (one cycle): pulse tx_pkt_start_o unless ISO, select the handshake in the priority order below, then go to StIdle.
- Handshake priority in StDecide:
  1. ISO endpoint: no handshake; acked if no overflow, else rollback; toggle unchanged.
  2. Not SETUP and out_ep_stall_i[ep]: STALL, rollback.
  3. out_ep_full_i[ep] or overflow: NAK, rollback.
  4. SETUP: ACK and acked; toggle[ep] <= 1. Stall is ignored. A DATA1 payload is treated as bad PID (rollback, no handshake).
  5. Data PID toggle bit != toggle[ep]: ACK, rollback, toggle unchanged (duplicate packet).
  6. Otherwise: ACK, acked, toggle[ep] flips.
- Handshake PIDs: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
- link_reset_i or !link_active_i in any state:
  - next state is StIdle, with no acked/rollback pulse;
  - a partially written packet is left to the buffer logic;
  - link_reset_i also zeroes the toggles.

## Timing
- Reset values: all outputs 0; state StIdle; counter = AckTimeoutCnt.
- out_ep_newpkt_o, out_ep_current_o, out_ep_setup_o: registered; valid the cycle after the token end.
- out_ep_data_put_o, out_ep_data_o, out_ep_put_addr_o: registered one cycle after rx_data_put_i. The address is the pre-increment offset; put_addr clears in StIdle.
- tx_pkt_start_o, tx_pid_o: combinational in StDecide, i.e. one cycle after the data end.
- out_ep_acked_o, out_ep_rollback_o: registered one cycle after the deciding cycle.
- Toggle updates take effect one cycle after StDecide.
- Timeout: the data start must arrive within AckTimeoutCnt+1 cycles of entering StRcvdOut.

## Test plan
- OUT ep2 (toggle 0), DATA0 with 8 bytes 0x00..0x07: put_addr 0..7 with matching data, ACK (0x2), one acked pulse, toggle[2]=1.
- Repeat the same DATA0 with toggle[2]=1: ACK sent, rollback pulse, no acked pulse, toggle[2] stays 1.
- SETUP ep0 while out_ep_stall_i[0]=1, DATA0 with 8 bytes: ACK, out_ep_setup_o=1, toggle[0]=1. A following OUT with DATA1 and stall still set: STALL (0xE), rollback.
- out_ep_full_i[1]=1, OUT ep1 DATA0: NAK (0xA), rollback, toggle unchanged. Separately, a 65-byte packet on a non-full endpoint: 64 writes, NAK.
- OUT token with no data packet: after 74 cycles, rollback pulse, no tx_pkt_start_o, back in StIdle. ISO ep3 with 5 bytes: no handshake, acked pulse.
- link_reset_i asserted mid-payload after 3 bytes: StIdle next cycle, no handshake, toggles 0. Token to endpoint 13 (≥ NumOutEps) or with a wrong address: no outputs change.
